// File: rtl/soc_system_pkg.sv
// Shared constants for the UART register bridge: command codes, reply byte,
// register addresses and the FSM state encodings.
package soc_system_pkg;

   localparam logic [7:0] CMD_WRITE     = 8'h57;
   localparam logic [7:0] CMD_READ      = 8'h52;
   localparam logic [7:0] ACK_BYTE      = 8'h4B;

   localparam logic [7:0] ADDR_GPIO_OUT = 8'h00;
   localparam logic [7:0] ADDR_GPIO_OE  = 8'h01;
   localparam logic [7:0] ADDR_GPIO_IN  = 8'h02;
   localparam logic [7:0] ADDR_LED_CTRL = 8'h03;

   typedef enum logic [1:0] {
      P_IDLE,
      P_CMD_ADDR,
      P_CMD_DATA,
      P_REPLY
   } parser_state_e;

   typedef enum logic [1:0] {
      RX_IDLE,
      RX_START,
      RX_DATA,
      RX_STOP
   } rx_state_e;

endpackage

// File: rtl/soc_system_if.sv
// Byte stream between the command parser (master) and the UART (slave).
// rx_vld is a 1-cycle pulse with no backpressure; tx_vld is honoured only while tx_busy is low.
interface soc_system_if;
   logic       rx_vld;
   logic [7:0] rx_dat;
   logic       tx_vld;
   logic [7:0] tx_dat;
   logic       tx_busy;

   modport master (input rx_vld, rx_dat, tx_busy, output tx_vld, tx_dat);
   modport slave  (output rx_vld, rx_dat, tx_busy, input tx_vld, tx_dat);
endinterface

// File: rtl/soc_uart.sv
// 8N1 UART, RX and TX sharing one divisor; rx_vld pulses one cycle after the stop-bit sample.
// TX accepts a byte only while idle; RX has no backpressure and drops bytes with a bad stop bit.
module soc_uart
   import soc_system_pkg::*;
#(
   parameter int clk_freq       = 50000000,
   parameter int uart_baud_rate = 115200
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        rxd,
   output logic        txd,
   soc_system_if.slave bus
);
   localparam int DIV  = clk_freq / uart_baud_rate;
   localparam int HALF = DIV / 2;
   localparam int CW   = $clog2(DIV);

   rx_state_e         rx_state_q, rx_state_d;
   logic              rxd_s1_q, rxd_s1_d;
   logic              rxd_s2_q, rxd_s2_d;
   logic              rxd_prev_q, rxd_prev_d;
   logic [CW-1:0]     rx_cnt_q, rx_cnt_d;
   logic [2:0]        rx_bit_q, rx_bit_d;
   logic [7:0]        rx_shift_q, rx_shift_d;
   logic              rx_vld_q, rx_vld_d;

   logic              tx_busy_q, tx_busy_d;
   logic [CW-1:0]     tx_cnt_q, tx_cnt_d;
   logic [3:0]        tx_bit_q, tx_bit_d;
   logic [9:0]        tx_shift_q, tx_shift_d;

   always_comb begin
      rxd_s1_d   = rxd;
      rxd_s2_d   = rxd_s1_q;
      rxd_prev_d = rxd_s2_q;
      rx_state_d = rx_state_q;
      rx_cnt_d   = rx_cnt_q + 1'b1;
      rx_bit_d   = rx_bit_q;
      rx_shift_d = rx_shift_q;
      rx_vld_d   = 1'b0;
      unique case (rx_state_q)
         RX_IDLE: begin
            rx_cnt_d = '0;
            if (rxd_prev_q && !rxd_s2_q) rx_state_d = RX_START;
         end
         // A start bit that is high again at mid-bit was a glitch.
         RX_START: if (rx_cnt_q == CW'(HALF - 1)) begin
            rx_cnt_d   = '0;
            rx_bit_d   = '0;
            rx_state_d = rxd_s2_q ? RX_IDLE : RX_DATA;
         end
         RX_DATA: if (rx_cnt_q == CW'(DIV - 1)) begin
            rx_cnt_d   = '0;
            rx_shift_d = {rxd_s2_q, rx_shift_q[7:1]};
            rx_bit_d   = rx_bit_q + 1'b1;
            if (rx_bit_q == 3'd7) rx_state_d = RX_STOP;
         end
         RX_STOP: if (rx_cnt_q == CW'(DIV - 1)) begin
            rx_vld_d   = rxd_s2_q;
            rx_state_d = RX_IDLE;
         end
         default: rx_state_d = RX_IDLE;
      endcase
   end

   always_comb begin
      tx_busy_d  = tx_busy_q;
      tx_cnt_d   = tx_cnt_q;
      tx_bit_d   = tx_bit_q;
      tx_shift_d = tx_shift_q;
      if (!tx_busy_q) begin
         if (bus.tx_vld) begin
            tx_busy_d  = 1'b1;
            tx_cnt_d   = '0;
            tx_bit_d   = '0;
            tx_shift_d = {1'b1, bus.tx_dat, 1'b0};
         end
      end else if (tx_cnt_q == CW'(DIV - 1)) begin
         tx_cnt_d   = '0;
         tx_shift_d = {1'b1, tx_shift_q[9:1]};
         tx_bit_d   = tx_bit_q + 1'b1;
         if (tx_bit_q == 4'd9) tx_busy_d = 1'b0;
      end else begin
         tx_cnt_d = tx_cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         rxd_s1_q   <= 1'b1;
         rxd_s2_q   <= 1'b1;
         rxd_prev_q <= 1'b1;
         rx_state_q <= RX_IDLE;
         rx_cnt_q   <= '0;
         rx_bit_q   <= '0;
         rx_shift_q <= '0;
         rx_vld_q   <= 1'b0;
         tx_busy_q  <= 1'b0;
         tx_cnt_q   <= '0;
         tx_bit_q   <= '0;
         tx_shift_q <= '1;
      end else begin
         rxd_s1_q   <= rxd_s1_d;
         rxd_s2_q   <= rxd_s2_d;
         rxd_prev_q <= rxd_prev_d;
         rx_state_q <= rx_state_d;
         rx_cnt_q   <= rx_cnt_d;
         rx_bit_q   <= rx_bit_d;
         rx_shift_q <= rx_shift_d;
         rx_vld_q   <= rx_vld_d;
         tx_busy_q  <= tx_busy_d;
         tx_cnt_q   <= tx_cnt_d;
         tx_bit_q   <= tx_bit_d;
         tx_shift_q <= tx_shift_d;
      end
   end

   assign bus.rx_vld  = rx_vld_q;
   assign bus.rx_dat  = rx_shift_q;
   assign bus.tx_busy = tx_busy_q;
   assign txd         = tx_busy_q ? tx_shift_q[0] : 1'b1;

endmodule

// File: rtl/soc_system.sv
// UART-controlled register file driving tristate GPIO and an LED; writes land the cycle after the data byte.
// Bytes arriving while a reply waits on the busy transmitter are dropped; SOC_SYSTEM_HEARTBEAT_EN adds an LED blinker.
module soc_system
   import soc_system_pkg::*;
#(
   parameter int clk_freq       = 50000000,
   parameter int uart_baud_rate = 115200,
   parameter int gpio_width     = 8
) (
   input  logic                 clk,
   input  logic                 rst,
   output logic                 led,
   input  logic                 uart_rxd,
   output logic                 uart_txd,
   inout  wire [gpio_width-1:0] gpio0_io
);
   soc_system_if uart_if ();

   soc_uart #(
      .clk_freq       (clk_freq),
      .uart_baud_rate (uart_baud_rate)
   ) u_uart (
      .clk (clk),
      .rst (rst),
      .rxd (uart_rxd),
      .txd (uart_txd),
      .bus (uart_if.slave)
   );

   parser_state_e         state_q, state_d;
   logic                  is_wr_q, is_wr_d;
   logic [7:0]            addr_q, addr_d;
   logic [7:0]            reply_q, reply_d;
   logic [gpio_width-1:0] gpio_out_q, gpio_out_d;
   logic [gpio_width-1:0] gpio_oe_q, gpio_oe_d;
   logic [gpio_width-1:0] gpio_s1_q, gpio_s1_d;
   logic [gpio_width-1:0] gpio_in_q, gpio_in_d;
   logic [1:0]            led_ctrl_q, led_ctrl_d;
   logic [7:0]            gpio_out_x, gpio_oe_x, gpio_in_x, rd_dat;
   logic                  tx_vld;

   always_comb begin
      gpio_out_x = '0;
      gpio_oe_x  = '0;
      gpio_in_x  = '0;
      gpio_out_x[gpio_width-1:0] = gpio_out_q;
      gpio_oe_x[gpio_width-1:0]  = gpio_oe_q;
      gpio_in_x[gpio_width-1:0]  = gpio_in_q;
   end

   // Read data is captured from the address byte itself, so the reply is ready on entry to REPLY.
   always_comb begin
      case (uart_if.rx_dat)
         ADDR_GPIO_OUT: rd_dat = gpio_out_x;
         ADDR_GPIO_OE:  rd_dat = gpio_oe_x;
         ADDR_GPIO_IN:  rd_dat = gpio_in_x;
         ADDR_LED_CTRL: rd_dat = {6'b0, led_ctrl_q};
         default:       rd_dat = 8'h00;
      endcase
   end

   always_comb begin
      state_d    = state_q;
      is_wr_d    = is_wr_q;
      addr_d     = addr_q;
      reply_d    = reply_q;
      gpio_out_d = gpio_out_q;
      gpio_oe_d  = gpio_oe_q;
      led_ctrl_d = led_ctrl_q;
      gpio_s1_d  = gpio0_io;
      gpio_in_d  = gpio_s1_q;
      tx_vld     = 1'b0;
      unique case (state_q)
         P_IDLE: if (uart_if.rx_vld) begin
            if (uart_if.rx_dat == CMD_WRITE) begin
               is_wr_d = 1'b1;
               state_d = P_CMD_ADDR;
            end else if (uart_if.rx_dat == CMD_READ) begin
               is_wr_d = 1'b0;
               state_d = P_CMD_ADDR;
            end
         end
         P_CMD_ADDR: if (uart_if.rx_vld) begin
            addr_d = uart_if.rx_dat;
            if (is_wr_q) begin
               state_d = P_CMD_DATA;
            end else begin
               reply_d = rd_dat;
               state_d = P_REPLY;
            end
         end
         P_CMD_DATA: if (uart_if.rx_vld) begin
            case (addr_q)
               ADDR_GPIO_OUT: gpio_out_d = uart_if.rx_dat[gpio_width-1:0];
               ADDR_GPIO_OE:  gpio_oe_d  = uart_if.rx_dat[gpio_width-1:0];
               ADDR_LED_CTRL: led_ctrl_d = uart_if.rx_dat[1:0];
               default: ;
            endcase
            reply_d = ACK_BYTE;
            state_d = P_REPLY;
         end
         P_REPLY: if (!uart_if.tx_busy) begin
            tx_vld  = 1'b1;
            state_d = P_IDLE;
         end
         default: state_d = P_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= P_IDLE;
         is_wr_q    <= 1'b0;
         addr_q     <= '0;
         reply_q    <= '0;
         gpio_out_q <= '0;
         gpio_oe_q  <= '0;
         gpio_s1_q  <= '0;
         gpio_in_q  <= '0;
         led_ctrl_q <= '0;
      end else begin
         state_q    <= state_d;
         is_wr_q    <= is_wr_d;
         addr_q     <= addr_d;
         reply_q    <= reply_d;
         gpio_out_q <= gpio_out_d;
         gpio_oe_q  <= gpio_oe_d;
         gpio_s1_q  <= gpio_s1_d;
         gpio_in_q  <= gpio_in_d;
         led_ctrl_q <= led_ctrl_d;
      end
   end

   assign uart_if.tx_vld = tx_vld;
   assign uart_if.tx_dat = reply_q;

   for (genvar i = 0; i < gpio_width; i++) begin : g_pad
      assign gpio0_io[i] = gpio_oe_q[i] ? gpio_out_q[i] : 1'bz;
   end

`ifdef SOC_SYSTEM_HEARTBEAT_EN
   localparam int HB_HALF = clk_freq / 2;
   localparam int HBW     = $clog2(HB_HALF);

   logic [HBW-1:0] hb_cnt_q, hb_cnt_d;
   logic           hb_q, hb_d;

   always_comb begin
      hb_cnt_d = hb_cnt_q + 1'b1;
      hb_d     = hb_q;
      if (hb_cnt_q == HBW'(HB_HALF - 1)) begin
         hb_cnt_d = '0;
         hb_d     = ~hb_q;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         hb_cnt_q <= '0;
         hb_q     <= 1'b0;
      end else begin
         hb_cnt_q <= hb_cnt_d;
         hb_q     <= hb_d;
      end
   end

   assign led = led_ctrl_q[1] ? led_ctrl_q[0] : hb_q;
`else
   assign led = led_ctrl_q[1] & led_ctrl_q[0];
`endif

endmodule

// File: tb/tb_soc_system.sv
// Drives 8N1 commands into soc_system and checks replies, pads and LED against a register-level model.
`timescale 1ns/1ps
module tb_soc_system;
`ifdef SOC_SYSTEM_HEARTBEAT_EN
   localparam int CLK_FREQ = 1000;
   localparam int BAUD     = 23;
`else
   localparam int CLK_FREQ = 50000000;
   localparam int BAUD     = 1152000;
`endif
   localparam int DIV = CLK_FREQ / BAUD;
   localparam int GW  = 8;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          uart_rxd = 1'b1;
   wire           uart_txd;
   wire           led;
   wire  [GW-1:0] gpio0_io;
   logic [GW-1:0] pad_drv = '0;
   logic [GW-1:0] pad_en  = '0;

   int checks = 0;
   int failures = 0;
   int txd_low = 0;
   byte unsigned reply_q[$];

   // register model
   logic [7:0] m_out = 8'h00;
   logic [7:0] m_oe  = 8'h00;
   logic [7:0] m_ctrl = 8'h00;

   soc_system_if host_if ();

   for (genvar i = 0; i < GW; i++) begin : g_bench_pad
      assign gpio0_io[i] = pad_en[i] ? pad_drv[i] : 1'bz;
   end

   always #10 clk = ~clk;

   soc_system #(
      .clk_freq       (CLK_FREQ),
      .uart_baud_rate (BAUD),
      .gpio_width     (GW)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .led      (led),
      .uart_rxd (uart_rxd),
      .uart_txd (uart_txd),
      .gpio0_io (gpio0_io)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   always @(negedge clk) if (uart_txd !== 1'b1) txd_low++;

   // host-side receiver: decodes every frame the DUT transmits
   initial begin : host_rx
      logic       prev;
      logic       ok;
      logic [7:0] b;
      prev = 1'b1;
      host_if.rx_vld = 1'b0;
      host_if.rx_dat = 8'h00;
      host_if.tx_busy = 1'b0;
      forever begin
         @(negedge clk);
         host_if.rx_vld = 1'b0;
         if (!rst && prev && !uart_txd) begin
            repeat (DIV / 2) @(negedge clk);
            ok = (uart_txd == 1'b0);
            for (int i = 0; i < 8; i++) begin
               repeat (DIV) @(negedge clk);
               b[i] = uart_txd;
            end
            repeat (DIV) @(negedge clk);
            ok = ok & uart_txd;
            check("tx_framing", 32'(ok), 32'd1);
            reply_q.push_back(b);
            host_if.rx_dat = b;
            host_if.rx_vld = 1'b1;
         end
         prev = uart_txd;
      end
   end

   task automatic send_byte(input logic [7:0] b, input logic stop_bit);
      logic [9:0] frame;
      frame = {stop_bit, b, 1'b0};
      host_if.tx_dat = b;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         uart_rxd = frame[i];
         repeat (DIV - 1) @(negedge clk);
      end
      @(negedge clk);
      uart_rxd = 1'b1;
   endtask

   task automatic expect_reply(input string tag, input logic [7:0] exp);
      int n;
      n = 0;
      while (reply_q.size() == 0 && n < 20 * DIV) begin
         @(negedge clk);
         n++;
      end
      if (reply_q.size() == 0) check({tag, "_timeout"}, 32'd0, 32'd1);
      else check(tag, 32'(reply_q.pop_front()), 32'(exp));
   endtask

   function automatic logic [7:0] m_read(input logic [7:0] a);
      case (a)
         8'h00:   return m_out;
         8'h01:   return m_oe;
         8'h02:   return (m_oe & m_out) | (~m_oe & pad_drv);
         8'h03:   return m_ctrl;
         default: return 8'h00;
      endcase
   endfunction

   task automatic do_write(input logic [7:0] a, input logic [7:0] d);
      send_byte(8'h57, 1'b1);
      send_byte(a, 1'b1);
      send_byte(d, 1'b1);
      case (a)
         8'h00:   m_out = d;
         8'h01:   m_oe = d;
         8'h03:   m_ctrl = {6'b0, d[1:0]};
         default: ;
      endcase
      pad_en = ~m_oe;
      expect_reply("wr_ack", 8'h4B);
   endtask

   task automatic do_read(input logic [7:0] a);
      logic [7:0] exp;
      exp = m_read(a);
      send_byte(8'h52, 1'b1);
      send_byte(a, 1'b1);
      expect_reply($sformatf("rd_%02h", a), exp);
   endtask

   task automatic check_outputs();
      @(negedge clk);
      check("pads", 32'(gpio0_io), 32'((m_oe & m_out) | (~m_oe & pad_drv)));
`ifdef SOC_SYSTEM_HEARTBEAT_EN
      if (m_ctrl[1]) check("led_manual", 32'(led), 32'(m_ctrl[0]));
`else
      check("led", 32'(led), 32'(m_ctrl[1] & m_ctrl[0]));
`endif
   endtask

   initial begin : main
      int low0;
      int led_hi;
      logic [7:0] junk;
      rst = 1'b1;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      check("reset_txd", 32'(uart_txd), 32'd1);
      check("reset_led", 32'(led), 32'd0);
      pad_drv = 8'h5A;
      pad_en  = 8'hFF;
      @(negedge clk);
      check("reset_pads_released", 32'(gpio0_io), 32'h5A);

      low0 = txd_low;
      led_hi = 0;
      for (int i = 0; i < 20000; i++) begin
         @(negedge clk);
         if (led) led_hi++;
      end
      check("idle_txd_low", 32'(txd_low - low0), 32'd0);
      check("idle_frames", 32'(reply_q.size()), 32'd0);

`ifdef SOC_SYSTEM_HEARTBEAT_EN
      check("hb_led_active", 32'(led_hi > 0), 32'd1);
      for (int k = 0; k < 2; k++) begin
         logic v;
         int n;
         v = led;
         n = 0;
         while (led == v && n < 2000) begin @(negedge clk); n++; end
         v = led;
         n = 0;
         while (led == v && n < 2000) begin @(negedge clk); n++; end
         check("hb_half_period", 32'(n), 32'd500);
      end
`else
      check("led_idle_off", 32'(led_hi), 32'd0);
`endif

      // write path
      do_write(8'h01, 8'hFF);
      do_write(8'h00, 8'hA5);
      check_outputs();
      check("pads_drive_a5", 32'(gpio0_io), 32'hA5);

      // read-back, including an unmapped address
      do_read(8'h00);
      do_read(8'h07);

      // input path
      do_write(8'h01, 8'h00);
      pad_drv = 8'h3C;
      do_read(8'h02);

      // a command code used as an operand
      do_write(8'h00, 8'h57);
      do_read(8'h00);

      // framing error then a valid LED write
      send_byte(8'h52, 1'b0);
      repeat (3 * DIV) @(negedge clk);
      do_write(8'h03, 8'h03);
      check_outputs();
      check("led_manual_on", 32'(led), 32'd1);
      check("no_stray_reply", 32'(reply_q.size()), 32'd0);

      for (int t = 0; t < 20; t++) begin
         int op;
         logic [7:0] a;
         logic [7:0] d;
         op = $urandom_range(0, 2);
         a  = 8'($urandom_range(0, 7));
         d  = 8'($urandom);
         if (op == 0) begin
            do_write(a, d);
         end else begin
            if (op == 2) begin
               junk = 8'($urandom);
               if (junk == 8'h57 || junk == 8'h52) junk = junk ^ 8'h01;
               send_byte(junk, 1'b1);
            end
            pad_drv = 8'($urandom);
            repeat (4) @(negedge clk);
            do_read(a);
         end
         check_outputs();
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
